// File: rtl/rv32i_data_mem.sv
// RV32I byte-addressed data memory with a valid/ready request/response
// handshake, configurable depth and response latency, funct3 load/store
// sizing with sign/zero extension, and error reporting.
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high; a response transfers on the rising edge where
// resp_valid and resp_ready are both high. Only one request is in flight,
// so req_ready is low from the accept edge until the response handshake.
module rv32i_data_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // state is kept as a named enum so checkers can bind to it directly
  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            offset;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  illegal;
  logic                  acc_err;
  logic [3:0]            byte_en;
  logic [31:0]           lane_data;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           load_data;

  assign accept       = req_valid & req_ready;
  assign word_idx     = req_addr[ADDR_WIDTH+1:2];
  assign offset       = req_addr[1:0];
  assign out_of_range = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
  assign illegal      = req_we ? (req_funct3 > 3'd2)
                               : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
  assign acc_err      = out_of_range | misaligned | illegal;

  // alignment depends only on the access size held in funct3[1:0]
  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'd1:    misaligned = offset[0];
      2'd2:    misaligned = (offset != 2'd0);
      default: misaligned = 1'b0;
    endcase
  end

  // lane enables and replicated store data so each lane takes its slice
  always_comb begin
    byte_en   = 4'b0000;
    lane_data = req_wdata;
    case (req_funct3[1:0])
      2'd0: begin
        byte_en   = 4'b0001 << offset;
        lane_data = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_wdata[15:0]}};
      end
      2'd2:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // load path: pick the addressed byte/half and extend per funct3
  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[{offset, 3'b000} +: 8];
  assign rd_half = offset[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = 32'd0;
    case (req_funct3)
      3'd0:    load_data = {{24{rd_byte[7]}}, rd_byte};
      3'd1:    load_data = {{16{rd_half[15]}}, rd_half};
      3'd2:    load_data = rd_word;
      3'd4:    load_data = {24'd0, rd_byte};
      3'd5:    load_data = {16'd0, rd_half};
      default: load_data = 32'd0;
    endcase
  end

  // store commits at the accept edge; the array is never reset
  always_ff @(posedge clk) begin
    if (accept && req_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][i*8 +: 8] <= lane_data[i*8 +: 8];
      end
    end
  end

  // request/response FSM with registered handshake outputs and latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      cnt        <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            resp_rdata <= (req_we || acc_err) ? 32'd0 : load_data;
            resp_err   <= acc_err;
            req_ready  <= 1'b0;
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            cnt        <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          cnt        <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/rv32i_data_mem.md
Name: rv32i_data_mem

Overview:
- Parametrised, byte-addressed RV32I data memory for the core's load/store unit and for directed tests.
- Supersedes the fixed 256-word, always-ready word memory. Adds configurable depth and response latency.
- Adds a valid/ready request/response handshake, RV32I load/store sizing (funct3) with sign/zero extension, byte-lane writes, and error reporting for misaligned, out-of-range and illegal accesses.

Parameters:
- ADDR_WIDTH, 8: word-index bits; depth = 2**ADDR_WIDTH 32-bit words; byte address span = 2**(ADDR_WIDTH+2).
- LATENCY, 1: cycles from the request-accept edge to resp_valid rising; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low byte/half/word is used according to funct3.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  the access was rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, latency counter = 0.
  - Memory array is NOT cleared; its contents are undefined until written.
- States:
  - IDLE: req_ready = 1. On req_valid & req_ready the request is accepted at that edge.
    - LATENCY = 1: go to RESP.
    - LATENCY > 1: go to WAIT with counter = LATENCY-1.
  - WAIT: req_ready = 0. Counter decrements each cycle; when it reaches 1, the next edge goes to RESP.
  - RESP: resp_valid = 1; resp_rdata and resp_err are held stable. On resp_valid & resp_ready go to IDLE.
- Timing and ordering:
  - resp_valid rises exactly LATENCY cycles after the accept edge.
  - The earliest next accept is the cycle after the response handshake. Only one request is ever outstanding.
- Decode (evaluated at the accept edge):
  - Word index = req_addr[ADDR_WIDTH+1:2]; byte offset = req_addr[1:0].
- Errors (no write, rdata 0, err 1):
  - Out of range: req_addr[31:ADDR_WIDTH+2] != 0.
  - Misaligned: half access with addr[0] = 1, or word access with addr[1:0] != 0.
  - Illegal funct3: stores with funct3 > 2; loads with funct3 in {3, 6, 7}.
- Stores:
  - The memory write commits at the accept edge.
  - Only the addressed lanes change: SB writes one byte at the offset; SH writes lanes {1:0} or {3:2}; SW writes all four.
  - Data for each lane comes from req_wdata[7:0], [15:0] or [31:0] respectively.
  - resp_rdata = 0.
- Loads:
  - The word is read at the accept edge; this is the pre-store value, which is irrelevant given one outstanding request.
  - The selected byte/half is right-justified. LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word.
  - The result is registered and presented in RESP.
- Reset mid-operation:
  - A reset in WAIT or RESP drops the response (resp_valid = 0 immediately) and returns to IDLE.
  - A store accepted before the reset stays committed.
- Input hygiene:
  - Requests in WAIT/RESP are ignored; req_ready = 0 in those states.
  - Inputs are don't-care when req_valid = 0.
  - resp_ready is ignored outside RESP.

Test Plan:
- LATENCY=1, ADDR_WIDTH=8: SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_valid one cycle after each accept; LW resp_rdata = 0xDEADBEEF, resp_err = 0.
- After the above: SB 0x7F @0x11, then LB @0x11 -> 0x0000007F. LW @0x10 -> 0xDEAD7FEF. LBU @0x13 -> 0x000000DE. LB @0x13 -> 0xFFFFFFDE. LH @0x12 -> 0xFFFFDEAD. LHU @0x12 -> 0x0000DEAD.
- Errors:
  - LW @0x12 -> resp_err = 1, rdata 0.
  - SH @0x11 -> resp_err = 1; a subsequent LW @0x10 is unchanged.
  - LW @0x400 (out of range for ADDR_WIDTH=8) -> resp_err = 1.
  - Load with funct3 = 3 -> resp_err = 1.
- LATENCY=4 with resp_ready held low 3 extra cycles:
  - resp_valid rises exactly 4 cycles after accept; rdata stays stable while stalled.
  - req_ready = 0 throughout; a req_valid asserted during the stall is not accepted.
  - The next accept occurs the cycle after the resp handshake.
- Reset mid-operation with LATENCY=4:
  - Accept SW 0x12345678 @0x20, then pulse rst_n low 2 cycles later -> resp_valid never rises and req_ready = 1 after reset.
  - A following LW @0x20 returns 0x12345678.
- Back-to-back traffic: resp_ready tied high, 50 random legal load/store ops checked against a byte-array reference model -> every response matches and resp_valid pulses exactly once per request.
